// File: rtl/sigdel_mc.sv
// Multi-channel sigma-delta DAC modulator with runtime 1st/2nd order selection.
// Shared prescaler strobe; each channel keeps its own accumulator/integrators.
module sigdel_mc #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned DIV_W    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      order2,
  input  logic [DIV_W-1:0]          div,
  input  logic                      load,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic                      ovf_clr,
  output logic [CHANNELS-1:0]       bitstream,
  output logic                      tick,
  output logic [CHANNELS-1:0]       ovf
);

  localparam int unsigned IW = WIDTH + 4;
  // Two extra bits so i2 + i1n - fb cannot wrap before the clamp is applied.
  localparam int unsigned CW = WIDTH + 6;
  localparam logic signed [CW-1:0] Half   = CW'(2 ** (WIDTH - 1));
  localparam logic signed [CW-1:0] SatMax = CW'(2 ** (WIDTH + 2) - 1);

  logic [DIV_W-1:0]          cnt_q, cnt_d;
  logic [CHANNELS*WIDTH-1:0] shadow_q, shadow_d;
  logic                      order_q, order_d;
  logic                      tick_q;
  logic                      strobe;
  logic                      order_chg;

  always_comb begin
    strobe    = en & (cnt_q >= div);
    order_chg = order2 != order_q;
    cnt_d     = cnt_q;
    if (strobe) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + DIV_W'(1);
    end
    order_d  = strobe ? order2 : order_q;
    shadow_d = load ? din : shadow_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      order_q  <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      order_q  <= order_d;
      tick_q   <= strobe;
    end
  end

  assign tick = tick_q;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [WIDTH-1:0]        x;
    logic [WIDTH-1:0]        acc_q, acc_d;
    logic [WIDTH:0]          sum;
    logic signed [CW-1:0]    e, fb, i1_r, i1_n, i2_r, i2_n;
    logic signed [IW-1:0]    i1_q, i1_d, i2_q, i2_d;
    logic                    bs_q, bs_d;
    logic                    ovf_q, ovf_d;
    logic                    clamp;

    always_comb begin
      x     = shadow_q[k*WIDTH +: WIDTH];
      sum   = {1'b0, acc_q} + {1'b0, x};
      e     = $signed(CW'(x)) - Half;
      fb    = bs_q ? Half : -Half;
      clamp = 1'b0;

      i1_r = CW'(i1_q) + e - fb;
      i1_n = i1_r;
      if (i1_r > SatMax) begin
        i1_n  = SatMax;
        clamp = 1'b1;
      end else if (i1_r < -SatMax) begin
        i1_n  = -SatMax;
        clamp = 1'b1;
      end

      i2_r = CW'(i2_q) + i1_n - fb;
      i2_n = i2_r;
      if (i2_r > SatMax) begin
        i2_n  = SatMax;
        clamp = 1'b1;
      end else if (i2_r < -SatMax) begin
        i2_n  = -SatMax;
        clamp = 1'b1;
      end

      acc_d = acc_q;
      i1_d  = i1_q;
      i2_d  = i2_q;
      bs_d  = bs_q;
      // A clamp in the same cycle as a clear keeps the flag set.
      ovf_d = ovf_q & ~ovf_clr;
      if (strobe) begin
        if (order_chg) begin
          acc_d = '0;
          i1_d  = '0;
          i2_d  = '0;
          bs_d  = 1'b0;
        end else if (order_q) begin
          i1_d = IW'(i1_n);
          i2_d = IW'(i2_n);
          bs_d = ~i2_n[CW-1];
          if (clamp) ovf_d = 1'b1;
        end else begin
          acc_d = sum[WIDTH-1:0];
          bs_d  = sum[WIDTH];
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_q <= '0;
        i1_q  <= '0;
        i2_q  <= '0;
        bs_q  <= 1'b0;
        ovf_q <= 1'b0;
      end else begin
        acc_q <= acc_d;
        i1_q  <= i1_d;
        i2_q  <= i2_d;
        bs_q  <= bs_d;
        ovf_q <= ovf_d;
      end
    end

    assign bitstream[k] = bs_q;
    assign ovf[k]       = ovf_q;
  end

endmodule

// File: tb/tb_sigdel_mc.sv
// Scoreboard bench for sigdel_mc: expected per-tick bitstreams are queued by the
// stimulus process and popped by a tick-driven monitor.
module tb_sigdel_mc;

  localparam int unsigned W  = 8;
  localparam int unsigned CH = 2;
  localparam int unsigned DW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic            order2;
  logic [DW-1:0]   div;
  logic            load;
  logic [CH*W-1:0] din;
  logic            ovf_clr;
  logic [CH-1:0]   bitstream;
  logic            tick;
  logic [CH-1:0]   ovf;

  sigdel_mc #(.WIDTH(W), .CHANNELS(CH), .DIV_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .order2    (order2),
    .div       (div),
    .load      (load),
    .din       (din),
    .ovf_clr   (ovf_clr),
    .bitstream (bitstream),
    .tick      (tick),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          chk;
    logic [CH-1:0] bits;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ones[CH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every tick must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && tick) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_tick: got tick with empty queue, expected none (t=%0t)", $time);
      end else begin
        cur = q.pop_front();
        for (int c = 0; c < CH; c++) ones[c] += int'(bitstream[c]);
        if (cur.chk) check("tick_bits", 32'(bitstream), 32'(cur.bits));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic chk, input logic [CH-1:0] bits);
    exp_t t;
    t.chk  = chk;
    t.bits = bits;
    q.push_back(t);
  endtask

  task automatic run_en(input int n);
    en = 1'b1;
    repeat (n) cyc();
    en = 1'b0;
  endtask

  task automatic drain(input string name);
    cyc();
    cyc();
    check(name, 32'(q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    q.delete();
    for (int c = 0; c < CH; c++) ones[c] = 0;
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic load_din(input logic [W-1:0] a0, input logic [W-1:0] a1);
    din  = {a1, a0};
    load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int            ecnt;
    int            cycles;
    logic [CH-1:0] prev;

    rst_n = 1'b0; en = 1'b0; order2 = 1'b0; div = '0; load = 1'b0; din = '0; ovf_clr = 1'b0;
    for (int c = 0; c < CH; c++) ones[c] = 0;
    repeat (2) cyc();
    check("reset_bitstream", 32'(bitstream), 32'd0);
    check("reset_tick", 32'(tick), 32'd0);
    check("reset_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    cyc();

    // 1st order, x=64 on ch0: 0,0,0,1 repeating; ch1 silent.
    load_din(8'd64, 8'd0);
    for (int i = 0; i < 256; i++) push(1'b1, {1'b0, (i % 4) == 3});
    run_en(256);
    drain("o1_x64_drain");
    check("o1_x64_ones_ch0", ones[0], 64);
    check("o1_x64_ones_ch1", ones[1], 0);

    // x=255 -> first 0 then all ones; x=128 -> alternating 0/1.
    do_reset();
    load_din(8'd255, 8'd128);
    for (int i = 0; i < 256; i++) push(1'b1, {(i % 2) == 1, i != 0});
    run_en(256);
    drain("o1_x255_drain");
    check("o1_x255_ones_ch0", ones[0], 255);
    check("o1_x128_ones_ch1", ones[1], 128);

    // div=3 with a 5-cycle en gap: tick every 4 enabled clocks, outputs frozen.
    do_reset();
    div = 4'd3;
    load_din(8'd128, 8'd128);
    push(1'b1, 2'b00); push(1'b1, 2'b11); push(1'b1, 2'b00); push(1'b1, 2'b11);
    ecnt = 0;
    for (int i = 0; i < 24; i++) begin
      en   = !(i >= 6 && i < 11);
      prev = bitstream;
      cyc();
      if (en) ecnt++;
      check("div3_tick", 32'(tick), 32'(en && (ecnt % 4) == 0));
      if (!en) check("frozen_bitstream", 32'(bitstream), 32'(prev));
    end
    en = 1'b0;
    drain("div3_drain");
    div = '0;

    // load coincident with strobe: strobe uses 32, next strobes use 200.
    do_reset();
    load_din(8'd32, 8'd32);
    push(1'b1, 2'b00); push(1'b1, 2'b00); push(1'b1, 2'b11);
    din  = {8'd200, 8'd200};
    load = 1'b1;
    en   = 1'b1;
    cyc();
    load = 1'b0;
    cyc();
    cyc();
    en = 1'b0;
    drain("load_strobe_drain");

    // 2nd order at mid-scale, then back to 1st order.
    do_reset();
    load_din(8'd128, 8'd128);
    order2 = 1'b1;
    for (int i = 0; i < 1024; i++) push(1'b0, 2'b00);
    run_en(1024);
    drain("o2_mid_drain");
    check("o2_mid_ones_ch0", 32'(ones[0] >= 510 && ones[0] <= 514), 32'd1);
    check("o2_mid_ones_ch1", 32'(ones[1] >= 510 && ones[1] <= 514), 32'd1);
    check("o2_mid_ovf", 32'(ovf), 32'd0);
    order2 = 1'b0;
    push(1'b1, 2'b00); push(1'b1, 2'b00); push(1'b1, 2'b11);
    push(1'b1, 2'b00); push(1'b1, 2'b11);
    run_en(5);
    drain("order_switch_drain");

    // Near full scale in 2nd order drives the integrators into the clamp.
    do_reset();
    load_din(8'd255, 8'd255);
    order2 = 1'b1;
    for (int i = 0; i < 4096; i++) push(1'b0, 2'b00);
    run_en(4096);
    drain("clamp_drain");
    check("clamp_ovf_set", 32'(ovf), 32'd3);
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
    check("ovf_cleared", 32'(ovf), 32'd0);

    // Asynchronous reset mid-run.
    for (int i = 0; i < 20; i++) push(1'b0, 2'b00);
    en = 1'b1;
    repeat (5) cyc();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_bitstream", 32'(bitstream), 32'd0);
    check("async_rst_tick", 32'(tick), 32'd0);
    check("async_rst_ovf", 32'(ovf), 32'd0);
    q.delete();
    en = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();

    // First strobe after release needs div+1 enabled cycles.
    div = 4'd2;
    push(1'b0, 2'b00);
    en = 1'b1;
    cycles = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      cycles++;
      if (tick) break;
    end
    en = 1'b0;
    check("first_strobe_latency", 32'(cycles), 32'd3);
    drain("latency_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
